// File: rtl/id_fwd_stage.sv
// Registered decode stage for logic, shift and LUI instructions.
// Resolves operands via forwarding, stalls on load-use, feeds the ID/EX latch.
module id_fwd_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               pc_i,
   input  logic [31:0]               inst_i,
   output logic                      re1_o,
   output logic                      re2_o,
   output logic [REG_AW-1:0]         raddr1_o,
   output logic [REG_AW-1:0]         raddr2_o,
   input  logic [DATA_W-1:0]         rdata1_i,
   input  logic [DATA_W-1:0]         rdata2_i,
   input  logic [NUM_FWD-1:0]        fwd_we_i,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr_i,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
   input  logic                      fwd0_is_load_i,
   input  logic                      flush_i,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               pc_o,
   output logic                      we_o,
   output logic [REG_AW-1:0]         waddr_o,
   output logic [7:0]                aluop_o,
   output logic [2:0]                alusel_o,
   output logic [DATA_W-1:0]         data1_o,
   output logic [DATA_W-1:0]         data2_o,
   output logic                      invalid_inst_o
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;

   localparam logic [7:0] ALU_AND = 8'h24;
   localparam logic [7:0] ALU_OR  = 8'h25;
   localparam logic [7:0] ALU_XOR = 8'h26;
   localparam logic [7:0] ALU_SLL = 8'h7C;
   localparam logic [7:0] ALU_SRL = 8'h02;
   localparam logic [7:0] ALU_SRA = 8'h03;

   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;

   logic [5:0]        op;
   logic [5:0]        funct;
   logic [4:0]        sa;
   logic [15:0]       imm;
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [REG_AW-1:0] rd;

   assign op    = inst_i[31:26];
   assign rs    = REG_AW'(inst_i[25:21]);
   assign rt    = REG_AW'(inst_i[20:16]);
   assign rd    = REG_AW'(inst_i[15:11]);
   assign sa    = inst_i[10:6];
   assign funct = inst_i[5:0];
   assign imm   = inst_i[15:0];

   logic              dec_re1;
   logic              dec_re2;
   logic              dec_we;
   logic [REG_AW-1:0] dec_waddr;
   logic [7:0]        dec_aluop;
   logic [2:0]        dec_alusel;
   logic [DATA_W-1:0] dec_imm1;
   logic [DATA_W-1:0] dec_imm2;
   logic              dec_inv;

   // Instruction decode: control fields and the non-register operand values
   always_comb begin
      dec_re1    = 1'b0;
      dec_re2    = 1'b0;
      dec_we     = 1'b0;
      dec_waddr  = '0;
      dec_aluop  = 8'h00;
      dec_alusel = SEL_NOP;
      dec_imm1   = '0;
      dec_imm2   = '0;
      dec_inv    = 1'b0;
      unique case (op)
         OP_ORI, OP_ANDI, OP_XORI: begin
            dec_re1    = 1'b1;
            dec_we     = 1'b1;
            dec_waddr  = rt;
            dec_alusel = SEL_LOGIC;
            dec_imm2   = DATA_W'(imm);
            dec_aluop  = (op == OP_ANDI) ? ALU_AND :
                         (op == OP_XORI) ? ALU_XOR : ALU_OR;
         end
         OP_LUI: begin
            dec_we     = 1'b1;
            dec_waddr  = rt;
            dec_alusel = SEL_LOGIC;
            dec_aluop  = ALU_OR;
            dec_imm2   = DATA_W'({imm, 16'h0000});
         end
         OP_SPECIAL: begin
            unique case (funct)
               FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                  dec_re1    = 1'b1;
                  dec_re2    = 1'b1;
                  dec_we     = 1'b1;
                  dec_waddr  = rd;
                  dec_alusel = SEL_LOGIC;
                  dec_aluop  = {2'b00, funct};
               end
               FN_SLL, FN_SRL, FN_SRA: begin
                  dec_re2    = 1'b1;
                  dec_we     = 1'b1;
                  dec_waddr  = rd;
                  dec_alusel = SEL_SHIFT;
                  dec_imm1   = DATA_W'(sa);
                  dec_aluop  = (funct == FN_SLL) ? ALU_SLL :
                               (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
               end
               default: dec_inv = 1'b1;
            endcase
         end
         default: dec_inv = 1'b1;
      endcase
   end

   assign re1_o    = in_valid & dec_re1;
   assign re2_o    = in_valid & dec_re2;
   assign raddr1_o = rs;
   assign raddr2_o = rt;

   // Youngest matching source wins, so scan from oldest and overwrite
   function automatic logic [DATA_W-1:0] resolve(
      input logic [REG_AW-1:0] a,
      input logic [DATA_W-1:0] rf
   );
      logic [DATA_W-1:0] r;
      r = rf;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_we_i[k] && fwd_waddr_i[k*REG_AW +: REG_AW] == a)
            r = fwd_wdata_i[k*DATA_W +: DATA_W];
      end
      if (a == '0)
         r = '0;
      return r;
   endfunction

   logic [DATA_W-1:0] opnd1;
   logic [DATA_W-1:0] opnd2;
   logic [REG_AW-1:0] fwd0_addr;
   logic              hazard;
   logic              load;

   // Operand selection: register path with forwarding, else immediate
   always_comb begin
      opnd1 = dec_re1 ? resolve(rs, rdata1_i) : dec_imm1;
      opnd2 = dec_re2 ? resolve(rt, rdata2_i) : dec_imm2;
   end

   assign fwd0_addr = fwd_waddr_i[REG_AW-1:0];

   assign hazard = in_valid & fwd_we_i[0] & fwd0_is_load_i &
                   ((re1_o & (rs == fwd0_addr) & (rs != '0)) |
                    (re2_o & (rt == fwd0_addr) & (rt != '0)));

   logic out_valid_q;
   logic out_valid_d;

   assign in_ready = ~hazard & ~flush_i & (~out_valid_q | out_ready);
   assign load     = in_valid & in_ready;

   logic [31:0]       pc_q,     pc_d;
   logic              we_q,     we_d;
   logic [REG_AW-1:0] waddr_q,  waddr_d;
   logic [7:0]        aluop_q,  aluop_d;
   logic [2:0]        alusel_q, alusel_d;
   logic [DATA_W-1:0] data1_q,  data1_d;
   logic [DATA_W-1:0] data2_q,  data2_d;
   logic              inv_q,    inv_d;

   // ID/EX latch next state: flush, load, bubble, consume, else hold
   always_comb begin
      out_valid_d = out_valid_q;
      pc_d        = pc_q;
      we_d        = we_q;
      waddr_d     = waddr_q;
      aluop_d     = aluop_q;
      alusel_d    = alusel_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      inv_d       = inv_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (load) begin
         out_valid_d = 1'b1;
         pc_d        = pc_i;
         we_d        = dec_we;
         waddr_d     = dec_waddr;
         aluop_d     = dec_aluop;
         alusel_d    = dec_alusel;
         data1_d     = opnd1;
         data2_d     = opnd2;
         inv_d       = dec_inv;
      end else if (hazard & (~out_valid_q | out_ready)) begin
         out_valid_d = 1'b0;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // ID/EX latch registers
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         pc_q        <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         aluop_q     <= '0;
         alusel_q    <= '0;
         data1_q     <= '0;
         data2_q     <= '0;
         inv_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         pc_q        <= pc_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         aluop_q     <= aluop_d;
         alusel_q    <= alusel_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         inv_q       <= inv_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign pc_o           = pc_q;
   assign we_o           = we_q;
   assign waddr_o        = waddr_q;
   assign aluop_o        = aluop_q;
   assign alusel_o       = alusel_q;
   assign data1_o        = data1_q;
   assign data2_o        = data2_q;
   assign invalid_inst_o = inv_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: decode vector table with scoreboard,
// plus load-use, back-pressure, flush and reset sequences.
module tb_id_fwd_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_i;
   logic [31:0] inst_i;
   logic        re1_o, re2_o;
   logic [4:0]  raddr1_o, raddr2_o;
   logic [31:0] rdata1_i, rdata2_i;
   logic [1:0]  fwd_we_i;
   logic [9:0]  fwd_waddr_i;
   logic [63:0] fwd_wdata_i;
   logic        fwd0_is_load_i;
   logic        flush_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_o;
   logic        we_o;
   logic [4:0]  waddr_o;
   logic [7:0]  aluop_o;
   logic [2:0]  alusel_o;
   logic [31:0] data1_o, data2_o;
   logic        invalid_inst_o;

   always #5 clk = ~clk;

   id_fwd_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_i(pc_i), .inst_i(inst_i),
      .re1_o(re1_o), .re2_o(re2_o),
      .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
      .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
      .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i),
      .fwd_wdata_i(fwd_wdata_i),
      .fwd0_is_load_i(fwd0_is_load_i),
      .flush_i(flush_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_o(pc_o), .we_o(we_o), .waddr_o(waddr_o),
      .aluop_o(aluop_o), .alusel_o(alusel_o),
      .data1_o(data1_o), .data2_o(data2_o),
      .invalid_inst_o(invalid_inst_o)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  wa;
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        inv;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [1:0]  fwe;
      logic [9:0]  fwa;
      logic [63:0] fwd;
      logic        ld;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   exp_t cur;
   exp_t held;
   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [31:0] ity(int op, int rs, int rt, int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] rty(int rs, int rt, int rd, int sa, int fn);
      return {6'h00, rs[4:0], rt[4:0], rd[4:0], sa[4:0], fn[5:0]};
   endfunction

   function automatic vec_t mv(
      logic [31:0] inst, logic [31:0] rd1, logic [31:0] rd2,
      logic [1:0] fwe, logic [4:0] fa0, logic [4:0] fa1,
      logic [31:0] fd0, logic [31:0] fd1, logic ld,
      logic we, logic [4:0] wa, logic [7:0] op, logic [2:0] sel,
      logic [31:0] d1, logic [31:0] d2, logic inv
   );
      vec_t v;
      v.inst = inst;
      v.rd1  = rd1;
      v.rd2  = rd2;
      v.fwe  = fwe;
      v.fwa  = {fa1, fa0};
      v.fwd  = {fd1, fd0};
      v.ld   = ld;
      v.e    = '{32'h0, we, wa, op, sel, d1, d2, inv};
      return v;
   endfunction

   function automatic exp_t act();
      return '{pc_o, we_o, waddr_o, aluop_o, alusel_o,
               data1_o, data2_o, invalid_inst_o};
   endfunction

   task automatic check(input string nm, input logic [127:0] got,
                        input logic [127:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic drive(input vec_t v, input logic [31:0] pc);
      in_valid       = 1'b1;
      pc_i           = pc;
      inst_i         = v.inst;
      rdata1_i       = v.rd1;
      rdata2_i       = v.rd2;
      fwd_we_i       = v.fwe;
      fwd_waddr_i    = v.fwa;
      fwd_wdata_i    = v.fwd;
      fwd0_is_load_i = v.ld;
      cur            = v.e;
      cur.pc         = pc;
   endtask

   // Mid-cycle: score the consumed output, queue the accepted input
   task automatic neg();
      exp_t e;
      @(negedge clk);
      if (out_valid && out_ready && !rst) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected got=%h want=none", act());
         end else begin
            e = sb.pop_front();
            check("out", 128'(act()), 128'(e));
         end
      end
      if (in_valid && in_ready && !rst)
         sb.push_back(cur);
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
   endtask

   vec_t v;

   initial begin
      rst = 1'b1; in_valid = 1'b0; pc_i = '0;
      inst_i = ity(13, 1, 2, 16'h00FF);
      rdata1_i = '0; rdata2_i = '0;
      fwd_we_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0;
      fwd0_is_load_i = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
      cur = '0; held = '0;

      // reset
      pos(); pos();
      neg();
      check("reset_outs",
            128'({out_valid, we_o, waddr_o, aluop_o, alusel_o,
                  data1_o, data2_o, pc_o, invalid_inst_o}), 128'(0));
      pos();
      rst = 1'b0;
      neg();
      check("ready_after_rst", 128'(in_ready), 128'(1));
      check("re_idle", 128'({re1_o, re2_o}), 128'(0));
      pos();

      // decode / forwarding table
      tbl.push_back(mv(ity(13,1,2,16'hFF00), 32'hF0, 0, 2'b00, 0, 0, 0, 0, 0,
                       1, 2, 8'h25, 3'd1, 32'hF0, 32'hFF00, 0));
      tbl.push_back(mv(rty(1,2,3,0,6'h25), 0, 32'h1234, 2'b11, 1, 1,
                       32'hAAAA, 32'h5555, 0,
                       1, 3, 8'h25, 3'd1, 32'hAAAA, 32'h1234, 0));
      tbl.push_back(mv(rty(1,2,3,0,6'h25), 0, 0, 2'b11, 1, 2,
                       32'hAAAA, 32'h1234, 0,
                       1, 3, 8'h25, 3'd1, 32'hAAAA, 32'h1234, 0));
      tbl.push_back(mv(rty(0,2,3,0,6'h25), 32'h77, 0, 2'b11, 0, 2,
                       32'hDEAD, 32'h1234, 1,
                       1, 3, 8'h25, 3'd1, 32'h0, 32'h1234, 0));
      tbl.push_back(mv(rty(0,7,4,3,6'h03), 0, 32'h8000_0000, 2'b00, 0, 0,
                       0, 0, 0,
                       1, 4, 8'h03, 3'd2, 32'h3, 32'h8000_0000, 0));
      tbl.push_back(mv(ity(15,5,8,16'h1234), 32'h99, 0, 2'b00, 0, 0, 0, 0, 0,
                       1, 8, 8'h25, 3'd1, 32'h0, 32'h1234_0000, 0));
      tbl.push_back(mv(ity(63,1,2,16'h5555), 1, 2, 2'b00, 0, 0, 0, 0, 0,
                       0, 0, 8'h00, 3'd0, 32'h0, 32'h0, 1));
      tbl.push_back(mv(32'h0, 32'h66, 32'h55, 2'b00, 0, 0, 0, 0, 0,
                       1, 0, 8'h7C, 3'd2, 32'h0, 32'h0, 0));
      tbl.push_back(mv(ity(14,10,9,16'h00FF), 32'hF0F0, 0, 2'b00, 0, 0,
                       0, 0, 0,
                       1, 9, 8'h26, 3'd1, 32'hF0F0, 32'hFF, 0));
      tbl.push_back(mv(ity(12,2,1,16'h8001), 32'h3, 0, 2'b10, 2, 2,
                       32'hBAD, 32'hFFFF_0001, 0,
                       1, 1, 8'h24, 3'd1, 32'hFFFF_0001, 32'h8001, 0));
      tbl.push_back(mv(rty(12,13,11,0,6'h27), 1, 2, 2'b01, 20, 0,
                       32'hEEEE, 0, 1,
                       1, 11, 8'h27, 3'd1, 32'h1, 32'h2, 0));
      tbl.push_back(mv(rty(0,6,5,31,6'h02), 0, 32'h9, 2'b01, 6, 0,
                       32'h1234, 0, 0,
                       1, 5, 8'h02, 3'd2, 32'h1F, 32'h1234, 0));
      tbl.push_back(mv(rty(0,6,5,4,6'h00), 0, 32'hF, 2'b00, 0, 0, 0, 0, 0,
                       1, 5, 8'h7C, 3'd2, 32'h4, 32'hF, 0));
      tbl.push_back(mv(rty(1,2,3,0,6'h20), 1, 2, 2'b00, 0, 0, 0, 0, 0,
                       0, 0, 8'h00, 3'd0, 32'h0, 32'h0, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i], 32'h100 + 32'(4 * i));
         neg();
         check("tbl_ready", 128'(in_ready), 128'(1));
         if (i == 0)
            check("ori_re", 128'({re1_o, re2_o}), 128'(2'b10));
         pos();
      end
      in_valid = 1'b0;
      neg(); pos();
      check("tbl_drained", 128'(sb.size()), 128'(0));

      // load-use stall
      drive(mv(rty(1,2,3,0,6'h25), 5, 6, 2'b00, 0, 0, 0, 0, 0,
               1, 3, 8'h25, 3'd1, 32'h5, 32'h6, 0), 32'h200);
      neg(); pos();
      drive(mv(ity(12,5,6,16'h0001), 32'h11, 0, 2'b01, 5, 0,
               32'h77, 0, 1,
               1, 6, 8'h24, 3'd1, 32'h77, 32'h1, 0), 32'h204);
      neg();
      check("lu_stall", 128'(in_ready), 128'(0));
      pos();
      neg();
      check("lu_bubble", 128'(out_valid), 128'(0));
      check("lu_stall2", 128'(in_ready), 128'(0));
      pos();
      fwd0_is_load_i = 1'b0;
      neg();
      check("lu_release", 128'(in_ready), 128'(1));
      pos();
      in_valid = 1'b0;
      neg(); pos();
      check("lu_drained", 128'(sb.size()), 128'(0));

      // back-pressure then flush
      drive(mv(ity(14,10,9,16'h00FF), 32'hF0F0, 0, 2'b00, 0, 0, 0, 0, 0,
               1, 9, 8'h26, 3'd1, 32'hF0F0, 32'hFF, 0), 32'h300);
      neg(); pos();
      held = sb[0];
      out_ready = 1'b0;
      drive(mv(ity(13,1,2,16'h0001), 32'h40, 0, 2'b00, 0, 0, 0, 0, 0,
               1, 2, 8'h25, 3'd1, 32'h40, 32'h1, 0), 32'h304);
      for (int c = 0; c < 3; c++) begin
         neg();
         check("bp_ctrl", 128'({out_valid, in_ready}), 128'(2'b10));
         check("bp_stable", 128'(act()), 128'(held));
         pos();
      end
      flush_i = 1'b1;
      neg();
      check("flush_ready", 128'(in_ready), 128'(0));
      pos();
      flush_i = 1'b0;
      void'(sb.pop_front());
      out_ready = 1'b1;
      neg();
      check("flush_ov", 128'(out_valid), 128'(0));
      pos();
      in_valid = 1'b0;
      neg(); pos();
      check("flush_drained", 128'(sb.size()), 128'(0));

      // reset during back-pressure
      drive(mv(ity(15,0,8,16'hBEEF), 0, 0, 2'b00, 0, 0, 0, 0, 0,
               1, 8, 8'h25, 3'd1, 32'h0, 32'hBEEF_0000, 0), 32'h400);
      neg(); pos();
      in_valid = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      pos();
      rst = 1'b0;
      sb.delete();
      neg();
      check("rst_mid", 128'({out_valid, in_ready, pc_o}), 128'({2'b01, 32'h0}));
      pos();
      out_ready = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_fwd_stage.md
# id_fwd_stage

Registered instruction-decode stage for the MIPS pipeline, replacing the purely combinational decoder between IF/ID and EX. It decodes logic, shift and LUI instructions. It resolves operands through a parametrised set of forwarding sources, detects load-use hazards and stalls on them. Results land in an output register (the ID/EX latch) with a valid/ready handshake and a synchronous flush.

## Interface
- DATA_W, 32, register/operand width
- REG_AW, 5, register address width
- NUM_FWD, 2, forwarding sources; index 0 = youngest (EX), higher = older (MEM, WB…)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pc_i/inst_i valid
- in_ready  out  1  stage accepts instruction this cycle
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- re1_o, re2_o  out  1  regfile read enables (combinational)
- raddr1_o, raddr2_o  out  REG_AW  regfile read addresses (combinational)
- rdata1_i, rdata2_i  in  DATA_W  regfile read data, same cycle
- fwd_we_i  in  NUM_FWD  per-source write enable
- fwd_waddr_i  in  NUM_FWD*REG_AW  per-source write address, source k at [k*REG_AW +: REG_AW]
- fwd_wdata_i  in  NUM_FWD*DATA_W  per-source write data
- fwd0_is_load_i  in  1  source 0 is a load; its data is not yet valid
- flush_i  in  1  discard output register and current input
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  EX consumes it
- pc_o  out  32 | we_o  out  1 | waddr_o  out  REG_AW
- aluop_o  out  8 | alusel_o  out  3
- data1_o, data2_o  out  DATA_W  resolved operands
- invalid_inst_o  out  1  decoded opcode/funct unsupported

## Operation
- Fields: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], funct=[5:0], imm=[15:0].
- Decode, all immediates zero-extended to DATA_W:
  - ORI 0x0D, ANDI 0x0C, XORI 0x0E: re1=1, re2=0, waddr=rt, alusel LOGIC 3'b001, aluop OR 0x25 / AND 0x24 / XOR 0x26, data2=imm.
  - LUI 0x0F: re1=0, data1=0, data2={imm,16'h0}, aluop OR, waddr=rt.
  - SPECIAL 0x00, funct AND 0x24, OR 0x25, XOR 0x26, NOR 0x27: re1=re2=1, waddr=rd, LOGIC, aluop=funct.
  - SPECIAL funct SLL 0x00, SRL 0x02, SRA 0x03: re1=0, data1=zero-extended sa, re2=1, waddr=rd, alusel SHIFT 3'b010, aluop SLL 0x7C / SRL 0x02 / SRA 0x03.
  - Anything else: we=0, aluop 0x00, alusel 3'b000, data1=data2=0, invalid_inst_o=1.
- raddr1_o=rs and raddr2_o=rt always; re*_o=0 while in_valid=0.
- Operand resolution, per read port with re=1:
  - Address 0 → 0, never forwarded.
  - Otherwise, the lowest k with fwd_we_i[k] and matching address → fwd_wdata k.
  - Otherwise → rdata.
  - With re=0 the operand is the immediate/sa/0 defined above.
- Load-use hazard = in_valid & fwd_we_i[0] & fwd0_is_load_i & (re1 & rs==fwd addr0 & rs≠0 | re2 & rt==fwd addr0 & rt≠0).
- in_ready = ~hazard & ~flush_i & (~out_valid | out_ready).
- Register update each clk, in priority order:
  - rst: all outputs 0.
  - flush_i: out_valid←0, other fields hold.
  - load=in_valid & in_ready: all fields←decode, out_valid←1.
  - hazard & (~out_valid | out_ready): out_valid←0 (bubble).
  - out_ready: out_valid←0.
  - Otherwise: hold.
- Nop encoding 0x00000000 decodes as SLL r0: valid, we=1, waddr=0; the regfile ignores writes to r0.

## Timing
- Reset values: out_valid, we_o, waddr_o, aluop_o, alusel_o, data1_o, data2_o, pc_o and invalid_inst_o all 0.
- Latency: accepted at edge N, visible at out_valid after edge N.
- Throughput: 1/cycle when out_ready=1; a new instruction loads on the same edge EX consumes the old one.
- Back-pressure: out_valid=1 & out_ready=0 → all outputs stable, in_ready=0.
- Hazard persists until source 0 no longer matches; EX sees one bubble per stalled cycle.
- Flush and in_valid in the same cycle: input not accepted, and the upstream stage must re-present or drop it.
- rst mid-stall or mid-flush: reset wins, and in_ready is valid from the first cycle after rst drops.

## Test plan
- Reset: rst=1 for 2 cycles → all outputs 0; after release, in_ready=1.
- ORI r2,r1,0xFF00 with r1=0x0000_00F0 from the regfile and no forwarding → next cycle aluop 0x25, alusel 1, data1 0xF0, data2 0xFF00, waddr 2, we 1.
- Forwarding priority: OR r3,r1,r2 with fwd0 (r1, 0xAAAA) and fwd1 (r1, 0x5555) and (r2, 0x1234), regfile 0 → data1 0xAAAA, data2 0x1234. Repeat with r1=r0 → data1 0.
- Load-use: fwd0 (r5, load) and ANDI r6,r5,1 → in_ready=0 and a bubble is emitted. Next cycle fwd0_is_load_i=0 → accepted.
- Back-pressure and flush: out_ready=0 for 3 cycles → outputs stable. flush_i for 1 cycle → out_valid=0 next cycle.
- Decode sweep: SRA r4,r7,3 → data1 3, aluop 0x03, alusel 2. LUI r8,0x1234 → data2 0x12340000. Opcode 0x3F → invalid_inst_o=1, we_o=0.
